// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the execute-stage ALU and ALU control.
//   alu_op_e   : 3-bit ALUCtl operation encoding
//   md_state_e : iterative multiply/divide sequencer states
//   hilo_t     : HI/LO register pair payload
package alu_muldiv_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_FORWARD = 3'b000,
    OP_OR      = 3'b001,
    OP_ADD     = 3'b010,
    OP_MFHI    = 3'b011,
    OP_MFLO    = 3'b100,
    OP_MUL     = 3'b101,
    OP_SUB     = 3'b110,
    OP_DIV     = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DIV_RUN = 2'd2,
    ST_FIX     = 2'd3
  } md_state_e;

  typedef struct packed {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
  } hilo_t;

  // True for the operations handled by the iterative unit.
  function automatic logic is_muldiv(input alu_op_e op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Pipeline <-> execute ALU bundle.
//   master (pipeline): drives A, B, ALUCtl, Start; receives Result, Zero,
//                      Busy, Stall, Done, DivZero.
//   slave  (ALU)     : the mirror image.
interface alu_muldiv_if;
  import alu_muldiv_pkg::*;

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  alu_op_e          ALUCtl;
  logic             Start;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Busy;
  logic             Stall;
  logic             Done;
  logic             DivZero;

  modport master (
    output A, B, ALUCtl, Start,
    input  Result, Zero, Busy, Stall, Done, DivZero
  );

  modport slave (
    input  A, B, ALUCtl, Start,
    output Result, Zero, Busy, Stall, Done, DivZero
  );

endinterface

// File: rtl/alu_muldiv_muldiv_iter.sv
// Iterative signed multiply / restoring divide sequencer.
//   clk, reset   : clock, synchronous active-high reset
//   i_start      : MUL/DIV request; accepted only while idle
//   i_op         : OP_MUL or OP_DIV
//   i_a, i_b     : operands, latched at accept
//   o_hilo_c     : sign-corrected HI/LO, valid while o_hilo_we_c is high
//   o_hilo_we_c  : HI/LO write strobe (FIX state)
//   o_busy       : operation in progress (RUN or FIX)
//   o_done       : one-cycle pulse after HI/LO were written
//   o_divzero    : sticky divide-by-zero flag
module alu_muldiv_muldiv_iter
  import alu_muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  alu_op_e          i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output hilo_t            o_hilo_c,
  output logic             o_hilo_we_c,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_divzero
);

  md_state_e          r_state,     w_state_nxt;
  logic [CNT_W-1:0]   r_cnt,       w_cnt_nxt;
  // MUL: {partial product, multiplier}; DIV: {remainder, quotient/dividend}
  logic [2*WIDTH-1:0] r_acc,       w_acc_nxt;
  // MUL: |A| (addend); DIV: |B| (divisor)
  logic [WIDTH-1:0]   r_opnd,      w_opnd_nxt;
  logic               r_neg_hi,    w_neg_hi_nxt;
  logic               r_neg_lo,    w_neg_lo_nxt;
  logic               r_is_mul,    w_is_mul_nxt;
  logic               r_dz,        w_dz_nxt;
  logic               r_divzero,   w_divzero_nxt;
  logic               r_done,      w_done_nxt;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_trial;
  logic [2*WIDTH-1:0] w_prod_neg;

  assign w_mag_a = i_a[WIDTH-1] ? -i_a : i_a;
  assign w_mag_b = i_b[WIDTH-1] ? -i_b : i_b;

  // Shift-add step: add |A| to the upper half when the multiplier LSB is set.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

  // Restoring step: shift next dividend bit into the remainder, trial-subtract.
  assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_trial = w_div_shift - {1'b0, r_opnd};

  assign w_prod_neg = -r_acc;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_neg_hi  <= 1'b0;
      r_neg_lo  <= 1'b0;
      r_is_mul  <= 1'b0;
      r_dz      <= 1'b0;
      r_divzero <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_acc     <= w_acc_nxt;
      r_opnd    <= w_opnd_nxt;
      r_neg_hi  <= w_neg_hi_nxt;
      r_neg_lo  <= w_neg_lo_nxt;
      r_is_mul  <= w_is_mul_nxt;
      r_dz      <= w_dz_nxt;
      r_divzero <= w_divzero_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_acc_nxt     = r_acc;
    w_opnd_nxt    = r_opnd;
    w_neg_hi_nxt  = r_neg_hi;
    w_neg_lo_nxt  = r_neg_lo;
    w_is_mul_nxt  = r_is_mul;
    w_dz_nxt      = r_dz;
    w_divzero_nxt = r_divzero;
    w_done_nxt    = 1'b0;
    o_hilo_we_c   = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_cnt_nxt     = '0;
          w_divzero_nxt = 1'b0;
          w_neg_lo_nxt  = i_a[WIDTH-1] ^ i_b[WIDTH-1];
          if (i_op == OP_MUL) begin
            w_state_nxt  = ST_MUL_RUN;
            w_acc_nxt    = {{WIDTH{1'b0}}, w_mag_b};
            w_opnd_nxt   = w_mag_a;
            w_neg_hi_nxt = i_a[WIDTH-1] ^ i_b[WIDTH-1];
            w_is_mul_nxt = 1'b1;
            w_dz_nxt     = 1'b0;
          end else if (i_b == '0) begin
            // Divide by zero bypasses RUN; FIX passes A / all-ones through.
            w_state_nxt  = ST_FIX;
            w_acc_nxt    = {i_a, {WIDTH{1'b1}}};
            w_opnd_nxt   = '0;
            w_neg_hi_nxt = 1'b0;
            w_is_mul_nxt = 1'b0;
            w_dz_nxt     = 1'b1;
          end else begin
            w_state_nxt  = ST_DIV_RUN;
            w_acc_nxt    = {{WIDTH{1'b0}}, w_mag_a};
            w_opnd_nxt   = w_mag_b;
            w_neg_hi_nxt = i_a[WIDTH-1];
            w_is_mul_nxt = 1'b0;
            w_dz_nxt     = 1'b0;
          end
        end
      end

      ST_MUL_RUN: begin
        w_acc_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(WIDTH-1)) w_state_nxt = ST_FIX;
      end

      ST_DIV_RUN: begin
        if (!w_div_trial[WIDTH]) begin
          w_acc_nxt = {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end else begin
          w_acc_nxt = {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(WIDTH-1)) w_state_nxt = ST_FIX;
      end

      ST_FIX: begin
        o_hilo_we_c = 1'b1;
        w_done_nxt  = 1'b1;
        if (r_dz) w_divzero_nxt = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sign fix-up of the unsigned magnitude result.
  always_comb begin
    o_hilo_c.hi = r_acc[2*WIDTH-1:WIDTH];
    o_hilo_c.lo = r_acc[WIDTH-1:0];
    if (!r_dz) begin
      if (r_is_mul) begin
        if (r_neg_hi) {o_hilo_c.hi, o_hilo_c.lo} = w_prod_neg;
      end else begin
        if (r_neg_hi) o_hilo_c.hi = -r_acc[2*WIDTH-1:WIDTH];
        if (r_neg_lo) o_hilo_c.lo = -r_acc[WIDTH-1:0];
      end
    end
  end

  assign o_busy    = (r_state != ST_IDLE);
  assign o_done    = r_done;
  assign o_divzero = r_divzero;

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU with architectural HI/LO and iterative MUL/DIV.
//   clk, reset : clock, synchronous active-high reset
//   bus.A/B    : operands (rs, rt/imm)
//   bus.ALUCtl : operation code
//   bus.Start  : instruction valid in EX
//   bus.Result : combinational result, bus.Zero = (Result == 0)
//   bus.Busy   : MUL/DIV in progress
//   bus.Stall  : hold EX (MUL/DIV/MFHI/MFLO issued while busy)
//   bus.Done   : one-cycle pulse after HI/LO update
//   bus.DivZero: sticky, last DIV had B == 0
module alu_muldiv
  import alu_muldiv_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  alu_muldiv_if.slave  bus
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  hilo_t            w_hilo;
  logic             w_hilo_we;
  logic             w_busy;
  logic             w_done;
  logic             w_divzero;
  logic             w_md_start;
  logic             w_needs_unit;
  logic [WIDTH-1:0] w_result;

  assign w_md_start = bus.Start && is_muldiv(bus.ALUCtl);

  alu_muldiv_muldiv_iter u_muldiv_iter (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_md_start),
    .i_op        (bus.ALUCtl),
    .i_a         (bus.A),
    .i_b         (bus.B),
    .o_hilo_c    (w_hilo),
    .o_hilo_we_c (w_hilo_we),
    .o_busy      (w_busy),
    .o_done      (w_done),
    .o_divzero   (w_divzero)
  );

  // Architectural HI/LO, written at the end of FIX.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_hilo_we) begin
      r_hi <= w_hilo.hi;
      r_lo <= w_hilo.lo;
    end
  end

  // Combinational operation mux; MUL/DIV report zero here.
  always_comb begin
    w_result = '0;
    unique case (bus.ALUCtl)
      OP_FORWARD: w_result = bus.A;
      OP_OR:      w_result = bus.A | bus.B;
      OP_ADD:     w_result = bus.A + bus.B;
      OP_SUB:     w_result = bus.A - bus.B;
      OP_MFHI:    w_result = r_hi;
      OP_MFLO:    w_result = r_lo;
      OP_MUL:     w_result = '0;
      OP_DIV:     w_result = '0;
      default:    w_result = '0;
    endcase
  end

  // Ops that touch the iterative unit or HI/LO must wait for it.
  assign w_needs_unit = is_muldiv(bus.ALUCtl) ||
                        (bus.ALUCtl == OP_MFHI) || (bus.ALUCtl == OP_MFLO);

  assign bus.Result  = w_result;
  assign bus.Zero    = (w_result == '0);
  assign bus.Busy    = w_busy;
  assign bus.Stall   = w_busy && bus.Start && w_needs_unit;
  assign bus.Done    = w_done;
  assign bus.DivZero = w_divzero;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (scoreboard of expected HI/LO/results).
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  alu_muldiv_if bus ();

  alu_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the multi-cycle ops.
  function automatic exp_t md_model(input string nm, input alu_op_e op,
                                    input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint p;
    int     sa;
    int     sb;
    e.name = nm;
    e.dz   = 1'b0;
    sa = int'(a);
    sb = int'(b);
    if (op == OP_MUL) begin
      p = longint'(sa) * longint'(sb);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
      e.dz = 1'b1;
    end else begin
      e.lo = 32'(sa / sb);
      e.hi = 32'(sa % sb);
    end
    return e;
  endfunction

  function automatic logic [31:0] comb_model(input alu_op_e op,
                                             input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_FORWARD: return a;
      OP_OR:      return a | b;
      OP_ADD:     return a + b;
      OP_SUB:     return a - b;
      default:    return 32'd0;
    endcase
  endfunction

  task automatic drive(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic st);
    bus.ALUCtl = op;
    bus.A      = a;
    bus.B      = b;
    bus.Start  = st;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(OP_FORWARD, 32'd0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.DivZero !== 1'b0 || bus.Stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b done=%b divzero=%b stall=%b, required all 0",
               bus.Busy, bus.Done, bus.DivZero, bus.Stall);
    end
    drive(OP_MFHI, 32'd0, 32'd0, 1'b1);
    #1;
    n_checks++;
    if (bus.Result !== 32'd0 || bus.Stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hi: result=%h stall=%b, required 0/0", bus.Result, bus.Stall);
    end
    drive(OP_MFLO, 32'd0, 32'd0, 1'b1);
    #1;
    n_checks++;
    if (bus.Result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_lo: result=%h, required 0", bus.Result);
    end
    drive(OP_FORWARD, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_comb;
    alu_op_e     ops[9] = '{OP_ADD, OP_SUB, OP_OR, OP_FORWARD, OP_ADD, OP_SUB,
                            OP_MUL, OP_DIV, OP_OR};
    logic [31:0] as[9]  = '{32'd5, 32'd9, 32'hF0, 32'hDEAD_BEEF, 32'hFFFF_FFFF,
                            32'd0, 32'd12, 32'd40, 32'd0};
    logic [31:0] bs[9]  = '{32'd7, 32'd9, 32'h0F, 32'd1, 32'd1, 32'd1,
                            32'd3, 32'd5, 32'd0};
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      e.name = $sformatf("comb_%0d", i);
      e.lo   = comb_model(ops[i], as[i], bs[i]);
      e.hi   = 32'd0;
      e.dz   = 1'b0;
      sb_q.push_back(e);
      // MUL/DIV are presented without Start so nothing is launched.
      drive(ops[i], as[i], bs[i], !is_muldiv(ops[i]));
      #1;
      e = sb_q.pop_front();
      n_checks++;
      if (bus.Result !== e.lo || bus.Zero !== (e.lo == 32'd0)) begin
        n_fail++;
        $display("FAIL %s: result=%h zero=%b, required %h/%b",
                 e.name, bus.Result, bus.Zero, e.lo, (e.lo == 32'd0));
      end
    end
    drive(OP_FORWARD, 32'd0, 32'd0, 1'b0);
    @(posedge clk);
    #1;
  endtask

  // Launches one MUL/DIV now and returns in its Done cycle after checking HI/LO.
  task automatic run_md(input string nm, input alu_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_done);
    exp_t e;
    int   cyc;
    int   busy_cnt;
    n_checks++;
    if (bus.Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: busy=%b at launch, required 0", nm, bus.Busy);
    end
    sb_q.push_back(md_model(nm, op, a, b));
    drive(op, a, b, 1'b1);
    @(posedge clk);
    #1;
    drive(OP_FORWARD, 32'd0, 32'd0, 1'b0);
    cyc = 1;
    busy_cnt = 0;
    while (bus.Done !== 1'b1 && cyc < 200) begin
      if (bus.Busy === 1'b1) busy_cnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    e = sb_q.pop_front();
    n_checks++;
    if (cyc !== exp_done || busy_cnt !== exp_done - 1 || bus.Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_timing: done_cycle=%0d busy_cycles=%0d busy_now=%b, required %0d/%0d/0",
               nm, cyc, busy_cnt, bus.Busy, exp_done, exp_done - 1);
    end
    drive(OP_MFHI, 32'd0, 32'd0, 1'b1);
    #1;
    n_checks++;
    if (bus.Result !== e.hi) begin
      n_fail++;
      $display("FAIL %s_hi: got %h, required %h", nm, bus.Result, e.hi);
    end
    drive(OP_MFLO, 32'd0, 32'd0, 1'b1);
    #1;
    n_checks++;
    if (bus.Result !== e.lo || bus.DivZero !== e.dz) begin
      n_fail++;
      $display("FAIL %s_lo: got %h divzero=%b, required %h/%b",
               nm, bus.Result, bus.DivZero, e.lo, e.dz);
    end
    drive(OP_FORWARD, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_mul;
    run_md("mul_m3x7", OP_MUL, 32'hFFFF_FFFD, 32'd7, 34);
    run_md("mul_max", OP_MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 34);
    run_md("mul_negneg", OP_MUL, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 34);
    run_md("mul_min", OP_MUL, 32'h8000_0000, 32'd3, 34);
    for (int i = 0; i < 3; i++) run_md($sformatf("mul_rand%0d", i), OP_MUL, $urandom, $urandom, 34);
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.Done !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_done_pulse: done=%b one cycle later, required 0", bus.Done);
    end
  endtask

  task automatic test_div;
    run_md("div_100_7", OP_DIV, 32'd100, 32'd7, 34);
    run_md("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 34);
    run_md("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 34);
    run_md("div_by0", OP_DIV, 32'd1234, 32'd0, 2);
    run_md("div_clr_dz", OP_DIV, 32'h8000_0001, 32'h0000_0010, 34);
    for (int i = 0; i < 2; i++)
      run_md($sformatf("div_rand%0d", i), OP_DIV, $urandom, 32'($urandom_range(1, 32'hFFFF)), 34);
  endtask

  task automatic test_back_to_back;
    run_md("b2b_div0", OP_DIV, 32'hCAFE_0000, 32'd0, 2);
    run_md("b2b_mul", OP_MUL, 32'd11, 32'hFFFF_FFFF, 34);
    run_md("b2b_div", OP_DIV, 32'd1000, 32'd33, 34);
  endtask

  task automatic test_stall;
    exp_t e;
    int   cyc;
    int   stall_bad;
    sb_q.push_back(md_model("stall_mul", OP_MUL, 32'd11, 32'd13));
    drive(OP_MUL, 32'd11, 32'd13, 1'b1);
    @(posedge clk);
    #1;
    cyc = 1;
    drive(OP_ADD, 32'd20, 32'd22, 1'b1);
    #1;
    n_checks++;
    if (bus.Stall !== 1'b0 || bus.Result !== 32'd42 || bus.Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_add: stall=%b result=%h busy=%b, required 0/0000002a/1",
               bus.Stall, bus.Result, bus.Busy);
    end
    drive(OP_MUL, 32'd2, 32'd2, 1'b1);
    #1;
    n_checks++;
    if (bus.Stall !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_mul_busy: stall=%b, required 1", bus.Stall);
    end
    drive(OP_MFLO, 32'd0, 32'd0, 1'b1);
    stall_bad = 0;
    while (bus.Busy === 1'b1 && cyc < 200) begin
      if (bus.Stall !== 1'b1) stall_bad++;
      @(posedge clk);
      #1;
      cyc++;
    end
    e = sb_q.pop_front();
    n_checks++;
    if (cyc !== 34 || stall_bad !== 0 || bus.Stall !== 1'b0 || bus.Done !== 1'b1 ||
        bus.Result !== e.lo) begin
      n_fail++;
      $display("FAIL stall_mflo: release_cycle=%0d stall_gaps=%0d stall=%b done=%b lo=%h, required 34/0/0/1/%h",
               cyc, stall_bad, bus.Stall, bus.Done, bus.Result, e.lo);
    end
    drive(OP_FORWARD, 32'd0, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_not_queued: busy=%b, required 0", bus.Busy);
    end
  endtask

  task automatic test_reset_mid_op;
    drive(OP_DIV, 32'd100, 32'd7, 1'b1);
    @(posedge clk);
    #1;
    drive(OP_FORWARD, 32'd0, 32'd0, 1'b0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (bus.Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_busy: busy=%b in cycle 10, required 1", bus.Busy);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_flags: busy=%b done=%b, required 0/0", bus.Busy, bus.Done);
    end
    drive(OP_MFHI, 32'd0, 32'd0, 1'b0);
    #1;
    n_checks++;
    if (bus.Result !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid_hi: got %h, required 0", bus.Result);
    end
    drive(OP_MFLO, 32'd0, 32'd0, 1'b0);
    #1;
    n_checks++;
    if (bus.Result !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid_lo: got %h, required 0", bus.Result);
    end
    drive(OP_FORWARD, 32'd0, 32'd0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_no_done: done=%b busy=%b, required 0/0", bus.Done, bus.Busy);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_comb();
    test_mul();
    test_div();
    test_back_to_back();
    test_stall();
    test_reset_mid_op();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
